// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding and sizing helpers for the modexp core.
package rsa_pkg;
  typedef enum logic [2:0] {IDLE, PRE_M, PRE_A, SQR, MUL, POST, DONE} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int MM_CYCLES = DEF_WIDTH + 2;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rsa_modexp_core_if.sv
// rsa_modexp_core_if: operand, handshake and result bundle of the modexp core.
interface rsa_modexp_core_if #(parameter int WIDTH = 8, parameter int EXP_WIDTH = WIDTH);
  logic en, start, abort;
  logic [WIDTH-1:0] p, m, cnst, c;
  logic [EXP_WIDTH-1:0] e;
  logic busy, eoc, err;
  modport master (output en, start, abort, p, e, m, cnst, input c, busy, eoc, err);
  modport slave (input en, start, abort, p, e, m, cnst, output c, busy, eoc, err);
endinterface

// File: rtl/rsa_modexp_core_mont_mul.sv
// mont_mul: radix-2 bit-serial Montgomery product a*b*2^-WIDTH mod p.
module mont_mul #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] r_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] a_q, b_q, p_q, r_q, r_d;
  logic [WIDTH+1:0] s_q, t, u, s_nx;
  logic [CW-1:0] cnt_q;
  logic busy_q, done_q, last, ge;
  // S stays below 2P, so every partial sum fits in WIDTH+2 bits
  assign t = s_q + (a_q[0] ? {2'b00, b_q} : '0);
  assign u = t + (t[0] ? {2'b00, p_q} : '0);
  assign s_nx = u >> 1;
  assign ge = s_nx >= {2'b00, p_q};
  assign r_d = s_nx[WIDTH-1:0] - (ge ? p_q : '0);
  assign last = cnt_q == CW'(WIDTH - 1);
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign r_o = r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      r_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (en_i) begin
      done_q <= 1'b0;
      if (start_i) begin
        a_q <= a_i;
        b_q <= b_i;
        p_q <= p_i;
        s_q <= '0;
        cnt_q <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        a_q <= a_q >> 1;
        s_q <= s_nx;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          r_q <= r_d;
        end
      end
    end
endmodule

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: C = M^E mod P via Montgomery square-and-multiply with
// start/busy/eoc handshake, abort, operand capture and error flagging.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EXP_WIDTH = WIDTH,
  parameter int CONST_TIME = 0
) (
  input logic clk,
  input logic rst,
  rsa_modexp_core_if.slave bus_if
);
  localparam int IW = cnt_w(EXP_WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] p_q, m_q, k_q, mb_q, acc_q, cint_q, c_q, op_a, op_b, mm_r;
  logic [EXP_WIDTH-1:0] e_q;
  logic [IW-1:0] i_q, i_d;
  logic perr_q, ent_q, eoc_q, err_q, mm_busy, mm_done, adv, ebit, last, bad_p, go;
  assign bad_p = !bus_if.p[0] || bus_if.p < WIDTH'(3);
  assign go = bus_if.start && !bus_if.abort;
  // a stale done from an aborted multiply can't advance a freshly entered state
  assign adv = mm_done && !mm_busy && !ent_q;
  assign ebit = e_q[i_q];
  assign last = i_q == '0;
  assign bus_if.c = c_q;
  assign bus_if.busy = !(state_q inside {IDLE, DONE});
  assign bus_if.eoc = eoc_q;
  assign bus_if.err = err_q;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    op_a = acc_q;
    op_b = acc_q;
    case (state_q)
      IDLE: begin
        state_d = go ? (bad_p ? DONE : PRE_M) : IDLE;
        i_d = IW'(EXP_WIDTH - 1);
      end
      PRE_M: begin
        op_a = m_q;
        op_b = k_q;
        state_d = adv ? PRE_A : PRE_M;
      end
      PRE_A: begin
        op_a = WIDTH'(1);
        op_b = k_q;
        state_d = adv ? SQR : PRE_A;
      end
      SQR: begin
        state_d = !adv ? SQR : (CONST_TIME != 0 || ebit) ? MUL : last ? POST : SQR;
        i_d = (adv && CONST_TIME == 0 && !ebit && !last) ? i_q - 1'b1 : i_q;
      end
      MUL: begin
        op_b = mb_q;
        state_d = !adv ? MUL : last ? POST : SQR;
        i_d = (adv && !last) ? i_q - 1'b1 : i_q;
      end
      POST: begin
        op_b = WIDTH'(1);
        state_d = adv ? DONE : POST;
      end
      default: state_d = IDLE;
    endcase
    if (bus_if.abort && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      {p_q, m_q, k_q, mb_q, acc_q, cint_q, c_q} <= '0;
      e_q <= '0;
      {perr_q, ent_q, eoc_q, err_q} <= '0;
    end else if (bus_if.en) begin
      state_q <= state_d;
      i_q <= i_d;
      ent_q <= (state_d inside {PRE_M, PRE_A, SQR, MUL, POST}) && (state_q == IDLE || adv);
      eoc_q <= 1'b0;
      err_q <= 1'b0;
      if (state_q == IDLE && go) begin
        p_q <= bus_if.p;
        e_q <= bus_if.e;
        m_q <= bus_if.m;
        k_q <= bus_if.cnst;
        perr_q <= bad_p;
      end
      if (adv)
        case (state_q)
          PRE_M: mb_q <= mm_r;
          PRE_A, SQR: acc_q <= mm_r;
          MUL: if (ebit) acc_q <= mm_r;
          POST: cint_q <= mm_r;
          default: ;
        endcase
      if (state_q == DONE && !bus_if.abort) begin
        eoc_q <= 1'b1;
        err_q <= perr_q;
        c_q <= perr_q ? '0 : cint_q;
      end
    end
  mont_mul #(.WIDTH(WIDTH)) u_mm (
    .clk(clk), .rst(rst), .en_i(bus_if.en), .start_i(ent_q),
    .a_i(op_a), .b_i(op_b), .p_i(p_q),
    .busy_o(mm_busy), .done_o(mm_done), .r_o(mm_r)
  );
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: drives a CONST_TIME=0 and a CONST_TIME=1 core with identical stimulus.
module tb_rsa_modexp_core;
  import rsa_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  rsa_modexp_core_if #(.WIDTH(8), .EXP_WIDTH(8)) if0 (), if1 ();
  rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8), .CONST_TIME(0)) dut0 (.clk(clk), .rst(rst), .bus_if(if0.slave));
  rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8), .CONST_TIME(1)) dut1 (.clk(clk), .rst(rst), .bus_if(if1.slave));
  typedef struct {int p; int e; int m; int c; int err;} vec_t;
  int n_cmp = 0, n_bad = 0;
  int lat[2], cres[2], eres[2], bsn[2];
  bit seen[2];
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int modexp(input int p, input int e, input int m);
    longint r = 1;
    for (int k = 0; k < e; k++) r = (r * m) % p;
    return int'(r);
  endfunction
  function automatic int elat(input int e, input int ct, input int bad);
    return bad != 0 ? 1 : (3 + 8 + (ct != 0 ? 8 : $countones(e[7:0]))) * MM_CYCLES + 1;
  endfunction
  task automatic drv(input int p, input int e, input int m);
    if0.p = 8'(p); if0.e = 8'(e); if0.m = 8'(m); if0.cnst = 8'(p > 0 ? 65536 % p : 0);
    if1.p = 8'(p); if1.e = 8'(e); if1.m = 8'(m); if1.cnst = 8'(p > 0 ? 65536 % p : 0);
  endtask
  task automatic ctl(input bit st, input bit ab, input bit en);
    if0.start = st; if0.abort = ab; if0.en = en;
    if1.start = st; if1.abort = ab; if1.en = en;
  endtask
  task automatic kick(input int p, input int e, input int m);
    drv(p, e, m);
    ctl(1, 0, 1);
    @(posedge clk);
    @(negedge clk);
    ctl(0, 0, 1);
  endtask
  // kind 1: extra start pulse at edge 'at'; kind 2: en low for 30 edges from 'at'
  task automatic go(input int p, input int e, input int m, input int kind, input int at);
    int n = 0;
    kick(p, e, m);
    seen = '{0, 0}; bsn = '{0, 0}; lat = '{-1, -1}; cres = '{-1, -1}; eres = '{-1, -1};
    while (!(seen[0] && seen[1]) && n < 800) begin
      ctl(kind == 1 && n == at, 0, !(kind == 2 && n >= at && n < at + 30));
      if (kind == 1 && n == at) drv(p, 3, 5);
      @(posedge clk);
      n++;
      @(negedge clk);
      if (if0.busy) bsn[0] = 1;
      if (if1.busy) bsn[1] = 1;
      if (if0.eoc && !seen[0]) begin seen[0] = 1; lat[0] = n; cres[0] = int'(if0.c); eres[0] = int'(if0.err); end
      if (if1.eoc && !seen[1]) begin seen[1] = 1; lat[1] = n; cres[1] = int'(if1.c); eres[1] = int'(if1.err); end
    end
    ctl(0, 0, 1);
  endtask
  task automatic chk_run(input string nm, input int e, input int c, input int err, input int extra);
    chk({nm, " c0"}, cres[0], c);
    chk({nm, " c1"}, cres[1], c);
    chk({nm, " err0"}, eres[0], err);
    chk({nm, " err1"}, eres[1], err);
    chk({nm, " lat0"}, lat[0], elat(e, 0, err) + extra);
    chk({nm, " lat1"}, lat[1], elat(e, 1, err) + extra);
    chk({nm, " busy0"}, bsn[0], err != 0 ? 0 : 1);
    chk({nm, " busy1"}, bsn[1], err != 0 ? 0 : 1);
  endtask
  initial begin
    vec_t tv[6];
    int p, e, m, neoc;
    tv[0] = '{187, 7, 88, 11, 0};
    tv[1] = '{187, 1, 88, 88, 0};
    tv[2] = '{187, 0, 88, 1, 0};
    tv[3] = '{187, 5, 0, 0, 0};
    tv[4] = '{186, 7, 88, 0, 1};
    tv[5] = '{1, 7, 0, 0, 1};
    drv(0, 0, 0);
    ctl(0, 0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset c0", int'(if0.c), 0);
    chk("reset busy0", int'(if0.busy), 0);
    chk("reset eoc0", int'(if0.eoc), 0);
    chk("reset err1", int'(if1.err), 0);
    for (int i = 0; i < 6; i++) begin
      go(tv[i].p, tv[i].e, tv[i].m, 0, 0);
      chk_run($sformatf("vec%0d", i), tv[i].e, tv[i].c, tv[i].err, 0);
    end
    for (int i = 0; i < 16; i++) begin
      p = 2 * $urandom_range(1, 127) + 1;
      m = $urandom_range(0, p - 1);
      e = $urandom_range(0, 255);
      go(p, e, m, 0, 0);
      chk_run($sformatf("rnd%0d p=%0d e=%0d m=%0d", i, p, e, m), e, modexp(p, e, m), 0, 0);
    end
    go(187, 7, 88, 1, 20);
    chk_run("start_while_busy", 7, 11, 0, 0);
    go(187, 7, 88, 2, 40);
    chk_run("en_low", 7, 11, 0, 30);
    kick(187, 7, 88);
    repeat (49) begin @(posedge clk); @(negedge clk); end
    ctl(0, 1, 1);
    @(posedge clk);
    @(negedge clk);
    ctl(0, 0, 1);
    chk("abort busy0", int'(if0.busy), 0);
    chk("abort busy1", int'(if1.busy), 0);
    neoc = 0;
    repeat (250) begin
      @(posedge clk);
      @(negedge clk);
      neoc += int'(if0.eoc) + int'(if1.eoc);
    end
    chk("abort no eoc", neoc, 0);
    chk("abort c0 kept", int'(if0.c), 11);
    chk("abort c1 kept", int'(if1.c), 11);
    drv(187, 7, 88);
    ctl(1, 1, 1);
    @(posedge clk);
    @(negedge clk);
    ctl(0, 0, 1);
    chk("start+abort busy0", int'(if0.busy), 0);
    chk("start+abort busy1", int'(if1.busy), 0);
    kick(187, 7, 88);
    repeat (60) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    chk("rst c0", int'(if0.c), 0);
    chk("rst c1", int'(if1.c), 0);
    chk("rst busy0", int'(if0.busy), 0);
    chk("rst busy1", int'(if1.busy), 0);
    chk("rst eoc0", int'(if0.eoc), 0);
    chk("rst err0", int'(if0.err), 0);
    @(negedge clk);
    rst = 1'b0;
    go(187, 7, 88, 0, 0);
    chk_run("after_rst", 7, 11, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
Parametrised successor to the fixed 8-bit RSA unit. Computes C = M^E mod P using bit-serial Montgomery multiplication and left-to-right square-and-multiply. It adds a start/busy/eoc handshake, abort, operand capture, error flagging and an optional constant-time mode. It sits between the register file (P, E, M, Const operands) and the enable/IRQ controller, replacing the previous RSA instance.

Parameters:
WIDTH, 8, width of P, M, Const and C; Montgomery radix R = 2^WIDTH.
EXP_WIDTH, WIDTH, width of exponent E.
CONST_TIME, 0, 1 = perform the multiply on every exponent bit and discard it when the bit is 0.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  clock enable; when low, all state, counters and outputs hold
start  in  1  single-cycle request; ignored while busy
abort  in  1  cancel current operation
P  in  WIDTH  modulus; odd and at least 3
E  in  EXP_WIDTH  exponent
M  in  WIDTH  message; must be < P
Const  in  WIDTH  R^2 mod P
C  out  WIDTH  result
busy  out  1  operation in progress
eoc  out  1  one-cycle end-of-computation pulse
err  out  1  operand error, valid with eoc

Behaviour:
- Reset: state IDLE. C=0, busy=0, eoc=0, err=0. Internal registers are cleared.
- One clock, asynchronous active-high reset. All logic advances only when en=1.
- start sampled with en=1 in IDLE:
  - P, E, M and Const are captured into internal registers.
  - Input changes after that point have no effect on the running operation.
- Error path: if captured P is even or P<3:
  - Next cycle: eoc=1, err=1, C=0, busy stays 0.
  - Return to IDLE.
- State machine: IDLE -> PRE_M -> PRE_A -> (SQR -> MUL?) x EXP_WIDTH -> POST -> DONE -> IDLE.
  - PRE_M: Mb = MM(M, Const).
  - PRE_A: A = MM(1, Const).
  - SQR: A = MM(A, A).
  - MUL: A = MM(A, Mb).
    - Entered when E[i]=1.
    - When CONST_TIME=1 it is always entered; the result is discarded if E[i]=0.
  - Bit index i runs from EXP_WIDTH-1 down to 0.
  - POST: C_int = MM(A, 1).
  - DONE: C <= C_int, eoc=1 for one cycle, err=0, busy=0.
- busy=1 from the cycle after start is accepted until the cycle eoc rises. busy=0 in DONE.
- Each multiply state issues mm_start on its entry cycle and exits on mm_done. Each multiply therefore occupies WIDTH+2 cycles.
- Latency: eoc is high exactly K*(WIDTH+2)+1 cycles after the start-sampling edge, where:
  - K = 3 + EXP_WIDTH + popcount(E) when CONST_TIME=0.
  - K = 3 + 2*EXP_WIDTH when CONST_TIME=1.
- MM(a, b) = a*b*R^-1 mod P, computed radix-2 and bit-serial:
  - S starts at 0.
  - For each bit j of a (LSB first): S += a_j*b; if S is odd, S += P; S >>= 1.
  - After WIDTH iterations, if S >= P then S -= P.
  - S is WIDTH+2 bits wide. Inputs must be < P; the output is < P.
- abort=1 (with en=1) in any non-IDLE state:
  - IDLE on the next edge, busy=0, no eoc.
  - C keeps its previous value.
  - abort in IDLE has no effect.
- start and abort in the same cycle: abort wins and start is dropped.
- start while busy is ignored; it is neither queued nor restarted.
- E=0: C = 1.
- M=0 with E>0: C = 0.
- en low mid-operation freezes everything. The latency above counts enabled cycles only. An eoc asserted when en falls stays high until the next enabled edge.
- Reset mid-operation: immediate return to the reset values.

Decomposition:
- Package rsa_pkg holds:
  - the FSM state enum (IDLE, PRE_M, PRE_A, SQR, MUL, POST, DONE);
  - the localparam MM_CYCLES = WIDTH+2;
  - the counter-width helper $clog2(EXP_WIDTH).
- Sub-module mont_mul (parameter WIDTH):
  - Ports: clk, rst, en, start, a, b, p, busy, done, r.
  - Latency: done pulses WIDTH+1 enabled cycles after start, with r valid while done=1.
  - Interface: the top FSM drives mont_mul only through start and the operand muxes.

Test Plan:
- WIDTH=8, P=187, E=7, M=88, Const=86, CONST_TIME=0 -> C=11, err=0, eoc exactly (3+8+3)*10+1=141 cycles after start.
- Same operands, CONST_TIME=1 -> C=11, eoc at (3+16)*10+1=191 cycles. Repeat with E=1 -> also 191 cycles, C=88.
- P=186 (even) start -> next cycle eoc=1, err=1, C=0, busy never 1. Repeat with P=1 -> same response.
- E=0, M=88, P=187 -> C=1. Then M=0, E=5 -> C=0.
- Start with P=187, E=7, M=88; abort at cycle 50 -> busy=0 the next cycle, no eoc, C unchanged. A second start pulsed at cycle 20 of a new run is ignored and the result is still 11 at cycle 141.
- Toggle en low for 30 cycles mid-run -> eoc delayed by exactly 30 cycles, C=11. Assert rst mid-run -> all outputs 0 at once.
